// File: rtl/qpp_deinterleaver.sv
// rtl/qpp_deinterleaver.sv - QPP de-interleaver with two ping-pong bit banks.
// Writes each incoming bit at pi(i), reads banks back in natural order.
module qpp_deinterleaver #(
   parameter int ADDR_W   = 13,
   parameter int K_SMALL  = 1056,
   parameter int F1_SMALL = 17,
   parameter int F2_SMALL = 66,
   parameter int K_LARGE  = 6144,
   parameter int F1_LARGE = 263,
   parameter int F2_LARGE = 480
) (
   input  logic clk,
   input  logic reset,
   input  logic data_in,
   input  logic in_start,
   input  logic in_blocksize,
   output logic data_out,
   output logic data_ready,
   output logic done,
   output logic busy,
   output logic overflow
);
   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_WRITING = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;
   localparam logic [1:0] ST_READING = 2'd3;

   localparam logic [ADDR_W-1:0] KS_M1 = ADDR_W'(K_SMALL - 1);
   localparam logic [ADDR_W-1:0] KL_M1 = ADDR_W'(K_LARGE - 1);
   localparam logic [ADDR_W-1:0] KS    = ADDR_W'(K_SMALL);
   localparam logic [ADDR_W-1:0] KL    = ADDR_W'(K_LARGE);
   localparam logic [ADDR_W-1:0] G0S   = ADDR_W'((F1_SMALL + F2_SMALL) % K_SMALL);
   localparam logic [ADDR_W-1:0] G0L   = ADDR_W'((F1_LARGE + F2_LARGE) % K_LARGE);
   localparam logic [ADDR_W-1:0] DS    = ADDR_W'((2 * F2_SMALL) % K_SMALL);
   localparam logic [ADDR_W-1:0] DL    = ADDR_W'((2 * F2_LARGE) % K_LARGE);

   // Both operands are already reduced, so one conditional subtract suffices.
   function automatic logic [ADDR_W-1:0] add_mod(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b,
                                                 input logic [ADDR_W-1:0] k);
      logic [ADDR_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, k}) s = s - {1'b0, k};
      return s[ADDR_W-1:0];
   endfunction

   logic [1:0][1:0]   st_q, st_d;
   logic [1:0]        sz_q, sz_d;
   logic              busy_q, busy_d, drop_q, drop_d, ovf_q, ovf_d;
   logic              nxt_q, nxt_d, wb_q, wb_d, wsz_q, wsz_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d, pi_q, pi_d, g_q, g_d;
   logic              rd_act_q, rd_act_d, rb_q, rb_d, rnx_q, rnx_d;
   logic [ADDR_W-1:0] ra_q, ra_d;
   logic              rdy_q, rdy_d, done_q, done_d;
   logic              rd_bit_q;

   logic              mem0 [0:K_LARGE-1];
   logic              mem1 [0:K_LARGE-1];

   logic [ADDR_W-1:0] k_w, k_w_m1, d_w, k_r_m1, waddr;
   logic              blk_last, wr_last, rd_last, nxt_free, start_ok, accept, we, wbank;
   logic [1:0]        full_now;

   assign k_w      = wsz_q ? KL : KS;
   assign k_w_m1   = wsz_q ? KL_M1 : KS_M1;
   assign d_w      = wsz_q ? DL : DS;
   assign k_r_m1   = sz_q[rb_q] ? KL_M1 : KS_M1;
   assign blk_last = (cnt_q == k_w_m1);
   assign wr_last  = busy_q && blk_last;
   assign rd_last  = rd_act_q && (ra_q == k_r_m1);
   assign nxt_free = (st_q[nxt_q] == ST_EMPTY) || (rd_last && (rb_q == nxt_q));
   assign start_ok = in_start && !busy_q && !drop_q;
   assign accept   = start_ok && nxt_free;
   assign full_now[0] = (st_q[0] == ST_FULL) || (wr_last && !wb_q);
   assign full_now[1] = (st_q[1] == ST_FULL) || (wr_last && wb_q);
   assign we       = accept || busy_q;
   assign wbank    = accept ? nxt_q : wb_q;
   assign waddr    = accept ? '0 : pi_q;

   always_comb begin
      st_d     = st_q;
      sz_d     = sz_q;
      busy_d   = busy_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      nxt_d    = nxt_q;
      wb_d     = wb_q;
      wsz_d    = wsz_q;
      cnt_d    = cnt_q;
      pi_d     = pi_q;
      g_d      = g_q;
      rd_act_d = rd_act_q;
      rb_d     = rb_q;
      rnx_d    = rnx_q;
      ra_d     = ra_q;
      rdy_d    = rd_act_q;
      done_d   = rd_last;

      // Order matters: free a bank, then write-side updates, then read start.
      if (rd_act_q) ra_d = ra_q + ADDR_W'(1);
      if (rd_last) begin
         st_d[rb_q] = ST_EMPTY;
         rd_act_d   = 1'b0;
      end

      if (accept) begin
         busy_d       = 1'b1;
         wb_d         = nxt_q;
         nxt_d        = ~nxt_q;
         wsz_d        = in_blocksize;
         cnt_d        = ADDR_W'(1);
         pi_d         = in_blocksize ? G0L : G0S;
         g_d          = in_blocksize ? add_mod(G0L, DL, KL) : add_mod(G0S, DS, KS);
         st_d[nxt_q]  = ST_WRITING;
         sz_d[nxt_q]  = in_blocksize;
      end else if (start_ok) begin
         drop_d = 1'b1;
         ovf_d  = 1'b1;
         wsz_d  = in_blocksize;
         cnt_d  = ADDR_W'(1);
      end else if (busy_q) begin
         cnt_d = cnt_q + ADDR_W'(1);
         pi_d  = add_mod(pi_q, g_q, k_w);
         g_d   = add_mod(g_q, d_w, k_w);
         if (blk_last) begin
            busy_d     = 1'b0;
            st_d[wb_q] = ST_FULL;
         end
      end else if (drop_q) begin
         cnt_d = cnt_q + ADDR_W'(1);
         if (blk_last) drop_d = 1'b0;
      end

      if ((!rd_act_q || rd_last) && full_now[rnx_q]) begin
         rd_act_d    = 1'b1;
         rb_d        = rnx_q;
         rnx_d       = ~rnx_q;
         ra_d        = '0;
         st_d[rnx_q] = ST_READING;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q     <= '0;
         sz_q     <= '0;
         busy_q   <= 1'b0;
         drop_q   <= 1'b0;
         ovf_q    <= 1'b0;
         nxt_q    <= 1'b0;
         wb_q     <= 1'b0;
         wsz_q    <= 1'b0;
         cnt_q    <= '0;
         pi_q     <= '0;
         g_q      <= '0;
         rd_act_q <= 1'b0;
         rb_q     <= 1'b0;
         rnx_q    <= 1'b0;
         ra_q     <= '0;
         rdy_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         st_q     <= st_d;
         sz_q     <= sz_d;
         busy_q   <= busy_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
         nxt_q    <= nxt_d;
         wb_q     <= wb_d;
         wsz_q    <= wsz_d;
         cnt_q    <= cnt_d;
         pi_q     <= pi_d;
         g_q      <= g_d;
         rd_act_q <= rd_act_d;
         rb_q     <= rb_d;
         rnx_q    <= rnx_d;
         ra_q     <= ra_d;
         rdy_q    <= rdy_d;
         done_q   <= done_d;
      end
   end

   // Bank contents are not reset; data_out is gated by data_ready instead.
   always_ff @(posedge clk) begin
      if (we && !wbank) mem0[waddr] <= data_in;
      if (we && wbank)  mem1[waddr] <= data_in;
      rd_bit_q <= rb_q ? mem1[ra_q] : mem0[ra_q];
   end

   assign data_out   = rdy_q & rd_bit_q;
   assign data_ready = rdy_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_qpp_deinterleaver.sv
// tb/tb_qpp_deinterleaver.sv - self-checking bench for qpp_deinterleaver.
module tb_qpp_deinterleaver;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic data_in = 1'b0;
   logic in_start = 1'b0;
   logic in_blocksize = 1'b0;
   logic data_out, data_ready, done, busy, overflow;

   qpp_deinterleaver dut (
      .clk(clk), .reset(reset), .data_in(data_in), .in_start(in_start),
      .in_blocksize(in_blocksize), .data_out(data_out), .data_ready(data_ready),
      .done(done), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit sz;
      int one_idx;
      int exp_pos;
   } vec_t;

   int  total = 0;
   int  bad = 0;
   int  zero_bad = 0;
   int  last_l = 0;
   bit  got_q[$];
   bit  exp_q[$];
   int  rdy_q[$];
   int  done_q[$];
   bit  blk [0:2][0:6143];
   bit  bsz [0:2];
   vec_t vecs [0:5];

   always @(negedge clk) begin
      if (!reset) begin
         if (data_ready) begin
            got_q.push_back(data_out);
            rdy_q.push_back(cyc + 1);
         end else if (data_out !== 1'b0) begin
            zero_bad++;
         end
         if (done) done_q.push_back(cyc + 1);
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic int kof(input bit sz);
      return sz ? 6144 : 1056;
   endfunction

   function automatic int pi_f(input bit sz, input int i);
      longint k, f1, f2, li;
      k  = sz ? 6144 : 1056;
      f1 = sz ? 263 : 17;
      f2 = sz ? 480 : 66;
      li = i;
      return int'((f1 * li + f2 * li * li) % k);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_q.delete();
      exp_q.delete();
      rdy_q.delete();
      done_q.delete();
   endtask

   task automatic add_exp(input int n);
      bit tmp [0:6143];
      int k;
      k = kof(bsz[n]);
      for (int i = 0; i < k; i++) tmp[pi_f(bsz[n], i)] = blk[n][i];
      for (int j = 0; j < k; j++) exp_q.push_back(tmp[j]);
   endtask

   task automatic rand_blk(input int n, input bit sz);
      bsz[n] = sz;
      for (int i = 0; i < 6144; i++) blk[n][i] = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input int n, input int busy_exp);
      int k;
      k = kof(bsz[n]);
      for (int i = 0; i < k; i++) begin
         tick();
         if (i == 10 && busy_exp >= 0) chk("busy_mid_block", busy, busy_exp);
         in_start     = (i == 0);
         in_blocksize = bsz[n];
         data_in      = blk[n][i];
         if (i == k - 1) last_l = cyc + 1;
      end
   endtask

   task automatic idle_in();
      tick();
      in_start = 1'b0;
      data_in  = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget, input string nm);
      int t;
      t = 0;
      while (done_q.size() < n && t < budget) begin
         tick();
         t++;
      end
      if (done_q.size() < n) chk({nm, "_timeout"}, done_q.size(), n);
      repeat (4) tick();
   endtask

   task automatic check_stream(input string nm);
      int mism, n;
      mism = 0;
      chk({nm, "_len"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int j = 0; j < n; j++) if (got_q[j] !== exp_q[j]) mism++;
      chk({nm, "_data"}, mism, 0);
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      int k, ones, pos;
      vecs[0] = '{1'b0, 1, 83};
      vecs[1] = '{1'b0, 3, 645};
      vecs[2] = '{1'b0, 0, 0};
      vecs[3] = '{1'b0, 1055, 49};
      vecs[4] = '{1'b1, 1, 743};
      vecs[5] = '{1'b1, 2, 2446};

      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_data_out", data_out, 0);
      chk("rst_data_ready", data_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);

      // Single-one blocks: position, latency and framing
      for (int v = 0; v < 6; v++) begin
         clear_mon();
         k = kof(vecs[v].sz);
         bsz[0] = vecs[v].sz;
         for (int i = 0; i < 6144; i++) blk[0][i] = 1'b0;
         blk[0][vecs[v].one_idx] = 1'b1;
         send(0, (v == 0) ? 1 : -1);
         idle_in();
         wait_done(1, 2 * k + 50, "vec");
         ones = 0;
         pos = -1;
         foreach (got_q[j]) if (got_q[j]) begin ones++; pos = j; end
         chk("vec_ones", ones, 1);
         chk("vec_pos", pos, vecs[v].exp_pos);
         chk("vec_rdy_len", rdy_q.size(), k);
         chk("vec_first_rdy", (rdy_q.size() > 0) ? rdy_q[0] : -1, last_l + 2);
         chk("vec_contig", (rdy_q.size() > 0) ? rdy_q[$] - rdy_q[0] + 1 : -1, k);
         chk("vec_done_cnt", done_q.size(), 1);
         chk("vec_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, last_l + k + 1);
      end

      // Random large block against the pi model
      clear_mon();
      rand_blk(0, 1'b1);
      add_exp(0);
      send(0, 1);
      idle_in();
      wait_done(1, 13000, "rand");
      check_stream("rand");
      chk("rand_overflow", overflow, 0);

      // Three back-to-back small blocks: no bubble
      clear_mon();
      for (int n = 0; n < 3; n++) begin
         rand_blk(n, 1'b0);
         add_exp(n);
      end
      send(0, -1);
      send(1, 1);
      send(2, -1);
      idle_in();
      wait_done(3, 5000, "b2b");
      chk("b2b_rdy_len", rdy_q.size(), 3168);
      chk("b2b_contig", (rdy_q.size() > 0) ? rdy_q[$] - rdy_q[0] + 1 : -1, 3168);
      chk("b2b_done_cnt", done_q.size(), 3);
      chk("b2b_done_gap", (done_q.size() > 1) ? done_q[1] - done_q[0] : -1, 1056);
      chk("b2b_overflow", overflow, 0);
      check_stream("b2b");

      // Large, small, small: third has no free bank and is dropped
      clear_mon();
      rand_blk(0, 1'b1);
      rand_blk(1, 1'b0);
      rand_blk(2, 1'b0);
      add_exp(0);
      add_exp(1);
      send(0, -1);
      send(1, 1);
      send(2, 0);
      idle_in();
      wait_done(2, 20000, "drop");
      repeat (300) tick();
      chk("drop_done_cnt", done_q.size(), 2);
      chk("drop_overflow", overflow, 1);
      check_stream("drop");
      do_reset();
      chk("drop_ovf_cleared", overflow, 0);

      // Reset mid-block while the previous block is still being read
      clear_mon();
      rand_blk(0, 1'b0);
      rand_blk(1, 1'b0);
      send(0, -1);
      for (int i = 0; i < 500; i++) begin
         tick();
         in_start = (i == 0);
         in_blocksize = 1'b0;
         data_in = blk[1][i];
      end
      tick();
      reset = 1'b1;
      in_start = 1'b0;
      data_in = 1'b0;
      #2;
      chk("mid_rst_ready", data_ready, 0);
      chk("mid_rst_data", data_out, 0);
      chk("mid_rst_busy", busy, 0);
      repeat (3) tick();
      reset = 1'b0;
      clear_mon();
      repeat (1200) tick();
      chk("stale_out", got_q.size(), 0);
      chk("stale_done", done_q.size(), 0);
      rand_blk(2, 1'b0);
      add_exp(2);
      send(2, 1);
      idle_in();
      wait_done(1, 2500, "fresh");
      check_stream("fresh");
      chk("fresh_done_cnt", done_q.size(), 1);
      chk("fresh_overflow", overflow, 0);
      chk("idle_zero", zero_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
